key_cmd_sched: RTL

KEY_CMD_SCHED -- requirements
Module: key_cmd_sched

---
 rtl/key_cmd_sched.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/key_cmd_sched.sv
// Keyboard command scheduler: press detection, optional auto-repeat FSM and a 4-deep FWFT command FIFO.
// Auto-repeat of direction keys is built only when KEY_AUTO_REPEAT_EN is defined.
module key_cmd_sched #(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] op_in,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] fifo_count,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, DELAY = 2'd2, REPEAT = 2'd3} state_t;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_p;
    logic [2:0] op_eff;
    logic       press;
    logic       enq;

    logic [2:0] mem_q [4];
    logic [1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       ovf_q, ovf_d;
    logic       deq, do_wr, full;

    // Code 7 is reserved and behaves exactly like a release.
    assign op_eff = (op_q == 3'd7) ? 3'd0 : op_q;
    assign press  = (op_eff != 3'd0) && (op_q != op_p);

`ifdef KEY_AUTO_REPEAT_EN
    localparam int MAXV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;
    localparam logic [CW-1:0] DELAY_LOAD  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LOAD = CW'(REPEAT_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        enq     = 1'b0;
        if (op_eff == 3'd0) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (press) begin
            enq = 1'b1;
            if (op_eff <= 3'd2) begin
                state_d = HOLD;
                cnt_d   = '0;
            end else begin
                state_d = DELAY;
                cnt_d   = DELAY_LOAD;
            end
        end else if (state_q == DELAY || state_q == REPEAT) begin
            if (cnt_q == '0) begin
                enq     = 1'b1;
                cnt_d   = PERIOD_LOAD;
                state_d = REPEAT;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    always_comb begin
        state_d = state_q;
        enq     = 1'b0;
        if (op_eff == 3'd0) begin
            state_d = IDLE;
        end else if (press) begin
            enq     = 1'b1;
            state_d = HOLD;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 3'd0;
            op_p    <= 3'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_in;
            op_p    <= op_q;
        end
    end

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign full  = (count_q == 3'd4);
    assign deq   = cmd_valid & cmd_ready;
    assign do_wr = enq & (~full | deq);

    always_comb begin
        wr_ptr_d = do_wr ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_wr, deq})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (enq & full & ~deq) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < 4; i++) mem_q[i] <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            if (do_wr) mem_q[wr_ptr_q] <= op_eff;
        end
    end

    assign cmd_valid   = (count_q != 3'd0);
    assign cmd         = cmd_valid ? mem_q[rd_ptr_q] : 3'd0;
    assign fifo_count  = count_q;
    assign overflow    = ovf_q;
    assign dbg_state_o = state_q;

endmodule
